uart_sender: RTL

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_sender_if.sv | 20 ++
 rtl/uart_sender.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_sender_if.sv
// CPU-side write port and serial-line outputs of the UART transmitter.
// The CPU (master) writes bytes; the transmitter (slave) reports FIFO and line status.
interface uart_sender_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       busy;
   logic       tx;
   logic       send_done;

   modport master (
      output wr_en, wr_data,
      input  full, busy, tx, send_done
   );

   modport slave (
      input  wr_en, wr_data,
      output full, busy, tx, send_done
   );
endinterface

// File: rtl/uart_sender.sv
// 8N1 UART transmitter fed by a small byte FIFO; tx and send_done are registered.
// One frame = start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
module uart_sender #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   uart_sender_if.slave bus
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic empty, full, push, pop, baud_end;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_FULL);
   // A pop on the same edge frees a slot, so a write while full is still accepted.
   assign pop      = (state_q == IDLE) && !empty;
   assign push     = bus.wr_en && (!full || pop);
   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // tx is registered, so it takes the bit that lands in shift[0] after this shift.
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.tx        = tx_q;
   assign bus.send_done = done_q;
   assign bus.full      = full;
   assign bus.busy      = !empty || (state_q != IDLE);
endmodule
